// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter that shares one spi_master among several requesters.
// The winner owns the master for a full transaction: word feed, slave select and response routing.
module spi_master_arbiter #(
    parameter int num_req_g    = 4,
    parameter int data_width_g = 8,
    parameter int addr_width_g = 2,
    parameter int len_width_g  = 8,
    parameter int timeout_g    = 1024
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [num_req_g-1:0]                 req_valid,
    input  logic [num_req_g*addr_width_g-1:0]    req_slave_addr,
    input  logic [num_req_g*len_width_g-1:0]     req_len,
    input  logic [num_req_g*data_width_g-1:0]    req_data,
    input  logic [num_req_g-1:0]                 req_data_valid,
    output logic [num_req_g-1:0]                 req_data_rd,
    output logic [num_req_g-1:0]                 req_grant,
    output logic [num_req_g-1:0]                 req_done,
    output logic [num_req_g-1:0]                 req_err,
    output logic [data_width_g-1:0]              rsp_data,
    output logic [num_req_g-1:0]                 rsp_valid,
    input  logic                                 mst_fifo_req_data,
    output logic [data_width_g-1:0]              mst_fifo_din,
    output logic                                 mst_fifo_din_valid,
    output logic                                 mst_fifo_empty,
    output logic [addr_width_g-1:0]              mst_slave_addr,
    input  logic                                 mst_busy,
    input  logic [data_width_g-1:0]              mst_dout,
    input  logic                                 mst_dout_valid
);

    localparam int SelW = (num_req_g > 1) ? $clog2(num_req_g) : 1;
    localparam int TmoW = $clog2(timeout_g + 1);

    typedef enum logic [2:0] {
        StIdle,
        StGrant,
        StXfer,
        StDrain,
        StDone,
        StErr
    } state_t;

    state_t                   r_state;
    state_t                   w_state_d;
    logic [SelW-1:0]          r_ptr;
    logic [SelW-1:0]          r_sel;
    logic [addr_width_g-1:0]  r_addr;
    logic [len_width_g-1:0]   r_len;
    logic [len_width_g-1:0]   r_cnt;
    logic [TmoW-1:0]          r_tmo;
    logic                     r_busy_q;
    logic                     r_busy_seen;
    logic [data_width_g-1:0]  r_din;
    logic                     r_din_valid;
    logic [num_req_g-1:0]     r_rd;
    logic [data_width_g-1:0]  r_rsp_data;
    logic [num_req_g-1:0]     r_rsp_valid;

    logic                     w_pick_hit;
    logic [SelW-1:0]          w_pick_sel;
    logic [num_req_g-1:0]     w_sel_oh;
    logic                     w_granted;
    logic                     w_active;
    logic                     w_cnt_full;
    logic                     w_empty;
    logic                     w_accept;
    logic                     w_busy_edge;
    logic                     w_tmo_hit;
    logic [SelW-1:0]          w_ptr_next;

    // First requesting index at or after the round-robin pointer, wrapping around.
    always_comb begin
        int v_idx;
        w_pick_hit = 1'b0;
        w_pick_sel = '0;
        for (int i = 0; i < num_req_g; i++) begin
            v_idx = (int'(r_ptr) + i) % num_req_g;
            if (!w_pick_hit && req_valid[v_idx]) begin
                w_pick_hit = 1'b1;
                w_pick_sel = SelW'(v_idx);
            end
        end
    end

    always_comb begin
        w_sel_oh        = '0;
        w_sel_oh[r_sel] = 1'b1;
    end

    assign w_granted   = (r_state != StIdle);
    assign w_active    = (r_state == StXfer) || (r_state == StDrain);
    assign w_cnt_full  = (r_cnt == r_len);
    assign w_empty     = (r_state == StXfer) ? (~req_data_valid[r_sel] | w_cnt_full) : 1'b1;
    assign w_accept    = (r_state == StXfer) & mst_fifo_req_data & ~w_empty;
    assign w_busy_edge = mst_busy ^ r_busy_q;
    // Any sign of life (accepted word or busy edge) restarts the idle window.
    assign w_tmo_hit   = w_active & ~w_accept & ~w_busy_edge & (r_tmo == TmoW'(timeout_g - 1));
    assign w_ptr_next  = (r_sel == SelW'(num_req_g - 1)) ? '0 : r_sel + 1'b1;

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_pick_hit) w_state_d = StGrant;
            end
            StGrant: begin
                w_state_d = (r_len == '0) ? StErr : StXfer;
            end
            StXfer: begin
                if (w_tmo_hit)       w_state_d = StErr;
                else if (w_cnt_full) w_state_d = StDrain;
            end
            StDrain: begin
                if (w_tmo_hit)                       w_state_d = StErr;
                else if (r_busy_seen && !mst_busy)   w_state_d = StDone;
            end
            StDone:  w_state_d = StIdle;
            StErr:   w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_ptr       <= '0;
            r_sel       <= '0;
            r_addr      <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_tmo       <= '0;
            r_busy_q    <= 1'b0;
            r_busy_seen <= 1'b0;
            r_din       <= '0;
            r_din_valid <= 1'b0;
            r_rd        <= '0;
            r_rsp_data  <= '0;
            r_rsp_valid <= '0;
        end else begin
            r_state     <= w_state_d;
            r_busy_q    <= mst_busy;
            r_din_valid <= w_accept;
            r_rd        <= w_accept ? w_sel_oh : '0;
            if (w_accept) begin
                r_din <= req_data[r_sel*data_width_g +: data_width_g];
            end

            // Responses outside a grant have no owner and are dropped.
            r_rsp_valid <= (w_granted && mst_dout_valid) ? w_sel_oh : '0;
            if (w_granted && mst_dout_valid) begin
                r_rsp_data <= mst_dout;
            end

            if (r_state == StIdle && w_pick_hit) begin
                r_sel  <= w_pick_sel;
                r_addr <= req_slave_addr[w_pick_sel*addr_width_g +: addr_width_g];
                r_len  <= req_len[w_pick_sel*len_width_g +: len_width_g];
            end

            if (r_state == StIdle)  r_cnt <= '0;
            else if (w_accept)      r_cnt <= r_cnt + 1'b1;

            if (!w_active)                  r_tmo <= '0;
            else if (w_accept || w_busy_edge) r_tmo <= '0;
            else                            r_tmo <= r_tmo + 1'b1;

            if (r_state == StIdle)          r_busy_seen <= 1'b0;
            else if (w_active && mst_busy)  r_busy_seen <= 1'b1;

            if (r_state == StDone || r_state == StErr) begin
                r_ptr <= w_ptr_next;
            end
        end
    end

    assign req_grant          = w_granted ? w_sel_oh : '0;
    assign req_done           = (r_state == StDone) ? w_sel_oh : '0;
    assign req_err            = (r_state == StErr) ? w_sel_oh : '0;
    assign req_data_rd        = r_rd;
    assign rsp_data           = r_rsp_data;
    assign rsp_valid          = r_rsp_valid;
    assign mst_fifo_din       = r_din;
    assign mst_fifo_din_valid = r_din_valid;
    assign mst_fifo_empty     = w_empty;
    assign mst_slave_addr     = w_granted ? r_addr : '0;

endmodule
